// File: rtl/multi_tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Optional fractional mode is selected by MULTI_TICK_GEN_FRAC_EN.
package multi_tick_gen_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    // Width of the configuration channel index (up to 16 channels).
    localparam int CH_IDX_W   = 4;

    // Divisors of 0 and 1 both mean "tick every cycle".
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/multi_tick_gen_if.sv
// Divisor configuration port of the tick generator.
// Handshake: cfg_we is a single-cycle valid strobe qualifying cfg_ch,
// cfg_div and cfg_frac; there is no ready, every strobe is accepted on the
// clock edge where it is seen, so back-to-back writes are legal. cfg_err is
// a registered one-cycle response to a strobe aimed at a missing channel.
interface multi_tick_gen_if
    import multi_tick_gen_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
);
    logic                cfg_we;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [DIV_W-1:0]    cfg_div;
    logic [FRAC_W-1:0]   cfg_frac;
    logic                cfg_err;

    modport master (output cfg_we, cfg_ch, cfg_div, cfg_frac, input cfg_err);
    modport slave  (input cfg_we, cfg_ch, cfg_div, cfg_frac, output cfg_err);
endinterface

// File: rtl/multi_tick_gen_tick_channel.sv
// One tick channel: period counter, terminal and mid-point compares, and
// (with MULTI_TICK_GEN_FRAC_EN) a fractional accumulator that stretches a
// period by one cycle on each carry-out.
module tick_channel
    import multi_tick_gen_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div,
    input  logic [FRAC_W-1:0] frac,
    output logic              tick,
    output logic              mid_tick
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] term;
    logic [DIV_W-1:0] mid_pt;
    logic             ext;
    logic             wrap;
    logic             mid_hit;

    assign d_eff = DIV_W'(eff_div(32'(div)));

`ifdef MULTI_TICK_GEN_FRAC_EN
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_sum;

    // The carry of the pending addition lengthens the period being counted now.
    assign {ext, acc_sum} = {1'b0, acc_q} + {1'b0, frac};

    // Accumulator advances once per wrap and restarts with the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (clr || !en) begin
            acc_q <= '0;
        end else if (wrap) begin
            acc_q <= acc_sum;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^frac;
    assign ext         = 1'b0;
`endif

    assign term    = d_eff - DIV_W'(1) + {{(DIV_W-1){1'b0}}, ext};
    assign mid_pt  = (d_eff >> 1) - DIV_W'(1);
    assign wrap    = (cnt_q == term);
    assign mid_hit = (d_eff >= DIV_W'(2)) ? (cnt_q == mid_pt) : wrap;

    // Counter and registered pulses; a clear or disable wins over a wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            tick     <= 1'b0;
            mid_tick <= 1'b0;
        end else if (clr || !en) begin
            cnt_q    <= '0;
            tick     <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            cnt_q    <= wrap ? '0 : cnt_q + DIV_W'(1);
            tick     <= wrap;
            mid_tick <= mid_hit;
        end
    end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator for the UART baud engines.
// Holds the divisor register file, write decode/error and restart fan-out.
// Define MULTI_TICK_GEN_FRAC_EN to build the fractional divisor support.
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 573,
    parameter int FRAC_W      = FRAC_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync_restart,
    multi_tick_gen_if.slave     cfg,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] mid_tick
);
    logic [DIV_W-1:0]    div_q   [CHANNELS];
    logic [FRAC_W-1:0]   ch_frac [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] clr;
    logic                ch_ok;
    logic                err_q;

    assign ch_ok       = (32'(cfg.cfg_ch) < 32'(CHANNELS));
    assign cfg.cfg_err = err_q;

    // Per-channel write select; a write or a global restart clears the channel.
    always_comb begin
        hit = '0;
        clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = cfg.cfg_we && (cfg.cfg_ch == CH_IDX_W'(i));
            clr[i] = hit[i] || sync_restart;
        end
    end

    // Integer divisor register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) div_q[i] <= DIV_W'(DEFAULT_DIV);
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i]) div_q[i] <= cfg.cfg_div;
            end
        end
    end

`ifdef MULTI_TICK_GEN_FRAC_EN
    logic [FRAC_W-1:0] frac_q [CHANNELS];

    // Fractional divisor register file, written alongside the integer part.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) frac_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i]) frac_q[i] <= cfg.cfg_frac;
            end
        end
    end

    assign ch_frac = frac_q;
`else
    logic unused_cfg_frac;
    assign unused_cfg_frac = ^cfg.cfg_frac;

    // Without fractional support every channel sees a zero fraction.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) ch_frac[i] = '0;
    end
`endif

    // One-cycle error pulse for a write to a channel that does not exist.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cfg.cfg_we && !ch_ok;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        tick_channel #(
            .DIV_W  (DIV_W),
            .FRAC_W (FRAC_W)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (ch_en[g]),
            .clr      (clr[g]),
            .div      (div_q[g]),
            .frac     (ch_frac[g]),
            .tick     (tick[g]),
            .mid_tick (mid_tick[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen. Expected pulse events are queued as
// {cycle, channel, is_mid} words (channel 15 = cfg_err) and matched in order
// against the pulses seen on each falling edge.
module tb_multi_tick_gen;
    import multi_tick_gen_pkg::*;

    localparam int CHANNELS    = 4;
    localparam int DIV_W       = 16;
    localparam int FRAC_W      = 4;
    localparam int DEFAULT_DIV = 573;
    localparam int EV_W        = 37;

    logic                clk;
    logic                reset_n;
    logic [CHANNELS-1:0] ch_en;
    logic                sync_restart;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] mid_tick;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [EV_W-1:0] exp_q[$];

    multi_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) cfg_bus ();

    multi_tick_gen #(
        .CHANNELS    (CHANNELS),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .FRAC_W      (FRAC_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg          (cfg_bus),
        .tick         (tick),
        .mid_tick     (mid_tick)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard helpers.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [EV_W-1:0] ev(input int unsigned t, input int ch, input logic mid);
        return {t, 4'(ch), mid};
    endfunction

    task automatic see_ev(input string tag, input logic [EV_W-1:0] e);
        if (exp_q.size() == 0) check_eq({tag, " unexpected"}, 64'(e), 64'd0);
        else                   check_eq(tag, 64'(e), 64'(exp_q.pop_front()));
    endtask

    task automatic drain(input string tag);
        check_eq({tag, " missing"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Expected pulses of a channel that started counting from zero after the
    // edge at cycle 'start', with divisor d, restricted to cycles lo..hi.
    task automatic push_periodic(input int ch, input int unsigned start, input int d,
                                 input int unsigned lo, input int unsigned hi);
        int unsigned p;
        p = (d < 2) ? 1 : 32'(d);
        for (int unsigned t = start + p; t <= hi; t += p) begin
            if (t >= lo) begin
                exp_q.push_back(ev(t, ch, 1'b0));
                if (p == 1) exp_q.push_back(ev(t, ch, 1'b1));
            end
        end
        if (p >= 2) begin
            for (int unsigned t = start + p / 2; t <= hi; t += p) begin
                if (t >= lo) exp_q.push_back(ev(t, ch, 1'b1));
            end
        end
    endtask

    // Observe n falling edges and match every pulse against the queue.
    task automatic run_window(input string tag, input int n);
        exp_q.sort();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < CHANNELS; c++) begin
                if (tick[c])     see_ev(tag, ev(cyc, c, 1'b0));
                if (mid_tick[c]) see_ev(tag, ev(cyc, c, 1'b1));
            end
            if (cfg_bus.cfg_err) see_ev(tag, ev(cyc, 15, 1'b0));
        end
    endtask

    // Driver: one-cycle divisor write, observed like any other cycle.
    task automatic cfg_write(input int ch, input int d, input int f, input string tag);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = CH_IDX_W'(ch);
        cfg_bus.cfg_div  = DIV_W'(d);
        cfg_bus.cfg_frac = FRAC_W'(f);
        run_window(tag, 1);
        cfg_bus.cfg_we   = 1'b0;
    endtask

    int unsigned t0, t1, s, r, g;

    initial begin
        reset_n          = 1'b0;
        ch_en            = '0;
        sync_restart     = 1'b0;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_div  = '0;
        cfg_bus.cfg_frac = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("reset_tick", 64'(tick), 64'd0);
        check_eq("reset_mid", 64'(mid_tick), 64'd0);
        check_eq("reset_err", 64'(cfg_bus.cfg_err), 64'd0);
        reset_n = 1'b1;
        run_window("idle_after_reset", 3);
        drain("idle_after_reset");

        // Default divisor 573 on channel 0.
        t0 = cyc;
        ch_en[0] = 1'b1;
        push_periodic(0, t0, DEFAULT_DIV, t0 + 1, t0 + 1150);
        run_window("ch0_div573", 1150);
        drain("ch0_div573");

        // Channel 1 at divisor 4 while channel 0 keeps its phase.
        t1 = cyc;
        push_periodic(0, t0, DEFAULT_DIV, t1 + 1, t1 + 601);
        cfg_write(1, 4, 0, "ch1_div4");
        ch_en[1] = 1'b1;
        push_periodic(1, t1 + 1, 4, t1 + 2, t1 + 601);
        run_window("ch1_div4", 600);
        drain("ch1_div4");
        ch_en = '0;
        repeat (3) @(negedge clk);

        // Divisor 1 then 0 on channel 2: tick every cycle, write cycle suppressed.
        s = cyc;
        ch_en[2] = 1'b1;
        push_periodic(2, s + 1, 1, s + 1, s + 8);
        cfg_write(2, 1, 0, "ch2_div1");
        run_window("ch2_div1", 7);
        drain("ch2_div1");
        s = cyc;
        push_periodic(2, s + 1, 0, s + 1, s + 9);
        cfg_write(2, 0, 0, "ch2_div0");
        run_window("ch2_div0", 8);
        drain("ch2_div0");
        ch_en[2] = 1'b0;
        run_window("ch2_disabled", 3);
        drain("ch2_disabled");

        // Out-of-range write: error pulse only, divisors untouched.
        s = cyc;
        exp_q.push_back(ev(s + 1, 15, 1'b0));
        cfg_write(7, 99, 0, "bad_ch_err");
        run_window("bad_ch_err", 3);
        drain("bad_ch_err");
        s = cyc;
        ch_en = 4'b1010;
        push_periodic(1, s, 4, s + 1, s + 580);
        push_periodic(3, s, DEFAULT_DIV, s + 1, s + 580);
        run_window("divs_kept", 580);
        drain("divs_kept");
        ch_en = '0;
        repeat (2) @(negedge clk);

        // Back-to-back writes 5/7/9/11, then a restart coincident with a write.
        cfg_write(0, 5, 0, "wr_5");
        cfg_write(1, 7, 0, "wr_7");
        cfg_write(2, 9, 0, "wr_9");
        cfg_write(3, 11, 0, "wr_11");
        drain("wr_seq");
        s = cyc;
        ch_en = 4'b1111;
        r = s + 14;
        push_periodic(0, s, 5, s + 1, r);
        push_periodic(1, s, 7, s + 1, r);
        push_periodic(2, s, 9, s + 1, r);
        push_periodic(3, s, 11, s + 1, r);
        run_window("pre_restart", 14);
        drain("pre_restart");
        push_periodic(0, r + 1, 6, r + 1, r + 31);
        push_periodic(1, r + 1, 7, r + 1, r + 31);
        push_periodic(2, r + 1, 9, r + 1, r + 31);
        push_periodic(3, r + 1, 11, r + 1, r + 31);
        sync_restart = 1'b1;
        cfg_write(0, 6, 0, "restart");
        sync_restart = 1'b0;
        run_window("post_restart", 30);
        drain("post_restart");
        ch_en = '0;
        repeat (2) @(negedge clk);

        // Reset asserted while tick[2] is high forces outputs low at once.
        s = cyc;
        ch_en = 4'b0100;
        push_periodic(2, s + 1, 1, s + 1, s + 4);
        cfg_write(2, 1, 0, "pre_async");
        run_window("pre_async", 3);
        drain("pre_async");
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_tick", 64'(tick), 64'd0);
        check_eq("async_mid", 64'(mid_tick), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        g = cyc;
        push_periodic(2, g, DEFAULT_DIV, g + 1, g + 580);
        run_window("after_async", 580);
        drain("after_async");
        ch_en = '0;
        repeat (2) @(negedge clk);

`ifdef MULTI_TICK_GEN_FRAC_EN
        // div 10, frac 4/16: every fourth period is 11 cycles, 16 periods = 164.
        cfg_write(0, 10, 4, "frac_wr");
        drain("frac_wr");
        s = cyc;
        ch_en[0] = 1'b1;
        t1 = s;
        for (int p = 1; p <= 16; p++) begin
            exp_q.push_back(ev(t1 + 5, 0, 1'b1));
            t1 += (p % 4 == 0) ? 11 : 10;
            exp_q.push_back(ev(t1, 0, 1'b0));
        end
        check_eq("frac_total", 64'(t1 - s), 64'd164);
        run_window("frac", 164);
        drain("frac");
        ch_en = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
